// File: rtl/tt_bist_harness.sv
// Built-in self-test harness for a Tiny Tapeout user design.
// It resets the DUT, drives a generated vector sequence into it, compresses the
// DUT responses into a MISR signature and compares that signature with a golden value.
module tt_bist_harness #(
    parameter int                    WIDTH_IN   = 8,
    parameter int                    WIDTH_OUT  = 8,
    parameter int                    SIG_W      = 16,
    parameter int                    CNT_W      = 16,
    parameter logic [WIDTH_IN-1:0]   POLY       = 8'hB8,
    parameter logic [SIG_W-1:0]      SIG_POLY   = 16'hB400,
    parameter int                    RST_CYCLES = 4,
    parameter int                    LAT        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WIDTH_IN-1:0]  seed,
    input  logic [CNT_W-1:0]     num_vectors,
    input  logic [SIG_W-1:0]     expected_sig,
    input  logic [WIDTH_OUT-1:0] dut_uo,
    output logic [WIDTH_IN-1:0]  dut_ui,
    output logic                 dut_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_W-1:0]     signature
);

    // Counter widths never collapse to zero bits, even for 1-cycle phases.
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LAT > 0) ? (LAT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DUT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH_IN-1:0]  vec_reg, vec_next;
    logic [1:0]           mode_reg, mode_next;
    logic [CNT_W-1:0]     nv_reg, nv_next;
    logic [CNT_W-1:0]     run_idx_reg, run_idx_next;
    logic [RC_W-1:0]      rst_cnt_reg, rst_cnt_next;
    logic [LAT_W-1:0]     drain_cnt_reg, drain_cnt_next;
    logic [SIG_W-1:0]     sig_reg, sig_next;
    logic [WIDTH_IN-1:0]  dut_ui_reg, dut_ui_next;
    logic                 dut_rst_n_reg, dut_rst_n_next;
    logic                 sample;
    logic [SIG_W-1:0]     uo_ext;
    logic [SIG_W-1:0]     misr_step;

    // Zero-extend the DUT outputs to the signature width, bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < SIG_W; gi++) begin : g_uo_ext
            if (gi < WIDTH_OUT) begin : g_bit
                assign uo_ext[gi] = dut_uo[gi];
            end else begin : g_zero
                assign uo_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // One MISR shift with the DUT response folded in.
    assign misr_step = {sig_reg[SIG_W-2:0], ^(sig_reg & SIG_POLY)} ^ uo_ext;

    // Next vector in the sequence for the latched mode.
    function automatic logic [WIDTH_IN-1:0] advance(input logic [1:0] m,
                                                    input logic [WIDTH_IN-1:0] v);
        logic [WIDTH_IN-1:0] r;
        case (m)
            2'd0:    r = {v[WIDTH_IN-2:0], ^(v & POLY)};
            2'd1:    r = v + WIDTH_IN'(1);
            2'd2:    r = {v[WIDTH_IN-2:0], v[WIDTH_IN-1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Next-state, counters, MISR and the values the output registers load.
    always_comb begin
        state_next     = state_reg;
        vec_next       = vec_reg;
        mode_next      = mode_reg;
        nv_next        = nv_reg;
        run_idx_next   = run_idx_reg;
        rst_cnt_next   = rst_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        sig_next       = sig_reg;
        dut_ui_next    = '0;
        dut_rst_n_next = 1'b1;
        sample         = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next     = S_RST_DUT;
                    sig_next       = '0;
                    nv_next        = num_vectors;
                    mode_next      = mode;
                    rst_cnt_next   = '0;
                    run_idx_next   = '0;
                    drain_cnt_next = '0;
                    // A zero LFSR seed would lock up; walking one ignores the seed.
                    if (mode == 2'd2 || (mode == 2'd0 && seed == '0)) begin
                        vec_next = WIDTH_IN'(1);
                    end else begin
                        vec_next = seed;
                    end
                end
            end
            S_RST_DUT: begin
                if (rst_cnt_reg == RC_LAST) begin
                    state_next = (nv_reg == '0) ? S_DONE : S_RUN;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RC_W'(1);
                end
            end
            S_RUN: begin
                // The first LAT responses belong to the DUT's reset state, not to a vector.
                sample = (32'(run_idx_reg) >= LAT);
                if (run_idx_reg == nv_reg - CNT_W'(1)) begin
                    state_next = (LAT == 0) ? S_DONE : S_DRAIN;
                end else begin
                    run_idx_next = run_idx_reg + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                // Only sample responses that map back to a vector actually applied.
                sample = (32'(nv_reg) + 32'(drain_cnt_reg) >= LAT);
                if (drain_cnt_reg == LAT_LAST) begin
                    state_next = S_DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + LAT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (sample) begin
            sig_next = misr_step;
        end

        // Pin values are registered, so they are computed for the state being entered.
        if (state_next == S_RST_DUT) begin
            dut_rst_n_next = 1'b0;
        end
        if (state_next == S_RUN) begin
            dut_ui_next = vec_reg;
            vec_next    = advance(mode_reg, vec_reg);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            vec_reg       <= '0;
            mode_reg      <= '0;
            nv_reg        <= '0;
            run_idx_reg   <= '0;
            rst_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            sig_reg       <= '0;
            dut_ui_reg    <= '0;
            dut_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            vec_reg       <= vec_next;
            mode_reg      <= mode_next;
            nv_reg        <= nv_next;
            run_idx_reg   <= run_idx_next;
            rst_cnt_reg   <= rst_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            sig_reg       <= sig_next;
            dut_ui_reg    <= dut_ui_next;
            dut_rst_n_reg <= dut_rst_n_next;
        end
    end

    assign dut_ui    = dut_ui_reg;
    assign dut_rst_n = dut_rst_n_reg;
    assign busy      = (state_reg == S_RST_DUT) || (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done      = (state_reg == S_DONE);
    assign pass      = done && (sig_reg == expected_sig);
    assign signature = sig_reg;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: one instance with a combinational loopback DUT
// (LAT = 0) and one with a two-stage registered loopback DUT (LAT = 2, CNT_W = 4),
// both driven by the same run requests and checked against a sequence model.
module tb_tt_bist_harness;

    localparam int RSTC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [7:0]  seed_i = 8'h00;
    logic [15:0] nv_i = 16'd0;
    logic [15:0] exp_sig = 16'h0000;

    logic [7:0]  ui0, uo0, ui2, uo2;
    logic        rn0, busy0, done0, pass0;
    logic        rn2, busy2, done2, pass2;
    logic [15:0] sig0, sig2;
    logic [7:0]  pipe1 = 8'h00;
    logic [7:0]  pipe2 = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign uo0 = ui0;
    assign uo2 = pipe2;

    // Registered loopback DUT with two cycles of latency.
    always @(posedge clk) begin
        pipe1 <= ui2;
        pipe2 <= pipe1;
    end

    tt_bist_harness #(.LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode_i), .seed(seed_i),
        .num_vectors(nv_i), .expected_sig(exp_sig), .dut_uo(uo0),
        .dut_ui(ui0), .dut_rst_n(rn0), .busy(busy0), .done(done0),
        .pass(pass0), .signature(sig0)
    );

    tt_bist_harness #(.LAT(2), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode_i), .seed(seed_i),
        .num_vectors(nv_i[3:0]), .expected_sig(exp_sig), .dut_uo(uo2),
        .dut_ui(ui2), .dut_rst_n(rn2), .busy(busy2), .done(done2),
        .pass(pass2), .signature(sig2)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return (v << 1) | 8'($countones(v & 8'hB8) % 2);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] sg, input logic [7:0] x);
        return ((sg << 1) | 16'($countones(sg & 16'hB400) % 2)) ^ {8'h00, x};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rn0, busy0, done0, pass0, ui0, sig0} !== 28'h0) begin
                errors++;
                $display("FAIL reset_u0 rst_n/busy/done/pass/ui/sig got %b/%b/%b/%b/%h/%h want 0/0/0/0/00/0000",
                         rn0, busy0, done0, pass0, ui0, sig0);
            end
            checks++;
            if ({rn2, busy2, done2, pass2, ui2, sig2} !== 28'h0) begin
                errors++;
                $display("FAIL reset_u2 rst_n/busy/done/pass/ui/sig got %b/%b/%b/%b/%h/%h want 0/0/0/0/00/0000",
                         rn2, busy2, done2, pass2, ui2, sig2);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rn0, busy0, done0, sig0, rn2, busy2, done2} !== {3'b100, 16'h0, 3'b100}) begin
            errors++;
            $display("FAIL idle rst_n/busy/done/sig u0 %b/%b/%b/%h u2 %b/%b/%b want 1/0/0/0000 and 1/0/0",
                     rn0, busy0, done0, sig0, rn2, busy2, done2);
        end
        $display("reset: idle after 2 reset cycles");
    endtask

    // Issues one run (start sampled on the next rising edge) and checks every cycle.
    task automatic run_case(input string name, input logic [1:0] m, input logic [7:0] s,
                            input logic [15:0] n, input logic [15:0] exp_in,
                            input logic golden, input int poke);
        logic [7:0]  vecs[$];
        logic [7:0]  v;
        logic [7:0]  eui;
        logic [15:0] msig;
        logic        erst_n;
        logic        eb0, ed0, eb2, ed2;
        int          d0, d2;

        v = (m == 2'd0 && s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < int'(n); i++) begin
            case (m)
                2'd0: begin vecs.push_back(v); v = lfsr_step(v); end
                2'd1: vecs.push_back(8'(int'(s) + i));
                2'd2: vecs.push_back(8'(1 << (i % 8)));
                default: vecs.push_back(s);
            endcase
        end
        msig = 16'h0000;
        foreach (vecs[k]) msig = misr_step(msig, vecs[k]);
        if (golden) exp_in = msig;

        d0 = 1 + RSTC + int'(n);
        d2 = (n == 16'd0) ? d0 : d0 + 2;

        mode_i = m; seed_i = s; nv_i = n; exp_sig = exp_in; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= d2; c++) begin
            eui = 8'h00;
            if (c > RSTC && c <= RSTC + int'(n)) eui = vecs[c - RSTC - 1];
            erst_n = (c > RSTC);
            eb0 = (c < d0); ed0 = (c >= d0);
            eb2 = (c < d2); ed2 = (c >= d2);
            checks++;
            if ({ui0, rn0, busy0, done0} !== {eui, erst_n, eb0, ed0}) begin
                errors++;
                $display("FAIL %s_u0 cycle %0d ui/rst_n/busy/done got %h/%b/%b/%b want %h/%b/%b/%b",
                         name, c, ui0, rn0, busy0, done0, eui, erst_n, eb0, ed0);
            end
            checks++;
            if ({ui2, rn2, busy2, done2} !== {eui, erst_n, eb2, ed2}) begin
                errors++;
                $display("FAIL %s_u2 cycle %0d ui/rst_n/busy/done got %h/%b/%b/%b want %h/%b/%b/%b",
                         name, c, ui2, rn2, busy2, done2, eui, erst_n, eb2, ed2);
            end
            if (c == poke) begin
                start = 1'b1; mode_i = ~m; seed_i = ~s; nv_i = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (c < d2) @(negedge clk);
        end

        checks++;
        if ({sig0, sig2} !== {msig, msig}) begin
            errors++;
            $display("FAIL %s_sig got u0 %h u2 %h want %h", name, sig0, sig2, msig);
        end
        checks++;
        if ({pass0, pass2} !== {2{exp_in == msig}}) begin
            errors++;
            $display("FAIL %s_pass got %b%b want %b%b (expected_sig %h)",
                     name, pass0, pass2, exp_in == msig, exp_in == msig, exp_in);
        end
        exp_sig = msig ^ 16'h8000;
        #1;
        checks++;
        if ({pass0, pass2} !== 2'b00) begin
            errors++;
            $display("FAIL %s_pass_wrong_golden got %b%b want 00", name, pass0, pass2);
        end
        exp_sig = msig;
        #1;
        checks++;
        if ({pass0, pass2} !== 2'b11) begin
            errors++;
            $display("FAIL %s_pass_right_golden got %b%b want 11", name, pass0, pass2);
        end
        $display("run %s: mode %0d seed %h n %0d signature %h", name, m, s, n, msig);
    endtask

    task automatic test_counter();
        run_case("counter", 2'd1, 8'h00, 16'd4, 16'h0003, 1'b0, 0);
        checks++;
        if (sig0 !== 16'h0003) begin
            errors++;
            $display("FAIL counter_sig_const got %h want 0003", sig0);
        end
        exp_sig = 16'h0004;
        #1;
        checks++;
        if (pass0 !== 1'b0) begin
            errors++;
            $display("FAIL counter_pass_0004 got %b want 0", pass0);
        end
    endtask

    task automatic test_patterns();
        run_case("lfsr_zero_seed", 2'd0, 8'h00, 16'd5, 16'h0000, 1'b1, 0);
        run_case("walking_one", 2'd2, 8'h5A, 16'd10, 16'h0000, 1'b1, 0);
        run_case("constant", 2'd3, 8'hC3, 16'd6, 16'h1234, 1'b0, 0);
    endtask

    task automatic test_start_busy();
        run_case("start_busy", 2'd1, 8'h10, 16'd6, 16'h0000, 1'b1, 7);
    endtask

    task automatic test_edge_lengths();
        run_case("zero_len", 2'd1, 8'h33, 16'd0, 16'h0000, 1'b0, 0);
        run_case("full_count", 2'd1, 8'hF0, 16'd15, 16'h0000, 1'b1, 0);
    endtask

    task automatic test_abort();
        mode_i = 2'd1; seed_i = 8'h00; nv_i = 16'd8; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({busy0, busy2, rn0} !== 3'b111) begin
            errors++;
            $display("FAIL abort_pre busy0/busy2/rst_n got %b/%b/%b want 1/1/1", busy0, busy2, rn0);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy0, done0, rn0, ui0, sig0, busy2, done2, sig2} !== 44'h0) begin
            errors++;
            $display("FAIL abort u0 busy/done/rst_n/ui/sig %b/%b/%b/%h/%h u2 busy/done/sig %b/%b/%h want all 0",
                     busy0, done0, rn0, ui0, sig0, busy2, done2, sig2);
        end
        @(negedge clk);
        checks++;
        if ({busy0, done0, rn0, sig0, busy2, rn2} !== {3'b001, 16'h0, 2'b01}) begin
            errors++;
            $display("FAIL abort_idle u0 busy/done/rst_n/sig %b/%b/%b/%h u2 busy/rst_n %b/%b want 0/0/1/0000 0/1",
                     busy0, done0, rn0, sig0, busy2, rn2);
        end
        $display("abort: reset mid-run returned to idle");
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [7:0]  s;
        logic [15:0] n;
        int          poke;
        for (int r = 0; r < 10; r++) begin
            m = 2'($urandom_range(0, 3));
            s = 8'($urandom);
            n = 16'($urandom_range(1, 15));
            poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, RSTC + int'(n)) : 0;
            run_case("random", m, s, n, 16'($urandom), 1'($urandom_range(0, 1)), poke);
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_patterns();
        test_start_busy();
        test_edge_lengths();
        test_abort();
        test_random();
        run_case("after_random", 2'd0, 8'h9C, 16'd7, 16'h0000, 1'b1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
